// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
// Holds the FSM state encoding, default timing constants and small
// constant functions used to size counters and the stage index.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      LOCK_FILT  = 3'd1,
      RELEASE    = 3'd2,
      RUN        = 3'd3,
      SW_HOLD_ST = 3'd4
   } seqState_t;

   localparam int DEF_LOCK_CYCLES = 64;
   localparam int DEF_STAGE_GAP   = 16;
   localparam int DEF_SW_HOLD     = 8;

   // Number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Largest of three timing constants, used to size the shared counter width.
   function automatic int maxOf3(input int a, input int b, input int c);
      int result;
      result = a;
      if (b > result) begin
         result = b;
      end
      if (c > result) begin
         result = c;
      end
      return result;
   endfunction

endpackage

// File: rtl/reset_seq_counter.sv
// Loadable saturating up-counter used for the lock filter, the stage gap
// and the software hold timers. Clear beats load, load beats increment,
// and the count parks at all-ones rather than wrapping.
module reset_seq_counter
   import reset_seq_pkg::*;
#(
   parameter int               WIDTH  = 7,
   parameter logic [WIDTH-1:0] TC_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_loadVal,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_count;

   // Count register: synchronous reset, then clear, load, saturating increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count >= TC_VAL);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: waits for a stable PLL lock, then releases
// NUM_STAGES subsystem resets one at a time, STAGE_GAP cycles apart.
// A software request re-asserts everything, holds for SW_HOLD cycles
// and re-runs the whole sequence.
// Optional build macro RESET_SEQ_LOCK_LOSS_EN: when defined, losing
// pll_lock during RELEASE or RUN re-asserts all resets and returns to
// WAIT_LOCK; when undefined, lock is only watched before release starts.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES  = 4,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
   parameter int STAGE_GAP   = DEF_STAGE_GAP,
   parameter int SW_HOLD     = DEF_SW_HOLD
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              pll_lock,
   input  logic                              sw_rst_req,
   output logic [NUM_STAGES-1:0]             rst_out,
   output logic                              seq_done,
   output logic [clog2(NUM_STAGES+1)-1:0]    stage_idx
);

   localparam int CNT_W = clog2(maxOf3(LOCK_CYCLES, STAGE_GAP, SW_HOLD) + 1);
   localparam int IDX_W = clog2(NUM_STAGES + 1);

   localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(STAGE_GAP - 1);
   localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(SW_HOLD - 1);
   localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

   seqState_t             r_state;
   logic [NUM_STAGES-1:0] r_rstOut;
   logic                  r_seqDone;
   logic [IDX_W-1:0]      r_stageIdx;

   logic             w_swAccept;
   logic             w_lockLoss;
   logic             w_lockLoad;
   logic             w_lockInc;
   logic             w_lockClr;
   logic             w_gapInc;
   logic             w_gapClr;
   logic             w_holdInc;
   logic             w_holdClr;
   logic [CNT_W-1:0] w_lockCnt;
   logic [CNT_W-1:0] w_gapCnt;
   logic [CNT_W-1:0] w_holdCnt;
   logic             w_lockTc;
   logic             w_gapTc;
   logic             w_holdTc;

   // Counter steering: mirrors the FSM priority so each counter is cleared
   // whenever its owning state is not active or is being left early.
   always_comb begin
      w_swAccept = sw_rst_req && (r_state != WAIT_LOCK);
      w_lockLoss = 1'b0;
`ifdef RESET_SEQ_LOCK_LOSS_EN
      w_lockLoss = !pll_lock && ((r_state == RELEASE) || (r_state == RUN));
`endif
      w_lockLoad = (r_state == WAIT_LOCK) && pll_lock;
      w_lockInc  = (r_state == LOCK_FILT) && pll_lock;
      w_lockClr  = w_swAccept || !(w_lockLoad || w_lockInc);
      w_gapInc   = (r_state == RELEASE);
      w_gapClr   = !w_gapInc || w_gapTc || w_swAccept || w_lockLoss;
      w_holdInc  = (r_state == SW_HOLD_ST);
      w_holdClr  = !w_holdInc || w_holdTc || w_swAccept;
   end

   reset_seq_counter #(
      .WIDTH  (CNT_W),
      .TC_VAL (LOCK_TC)
   ) u_lockCnt (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_lockClr),
      .i_load    (w_lockLoad),
      .i_loadVal (CNT_W'(1)),
      .i_inc     (w_lockInc),
      .o_count   (w_lockCnt),
      .o_tc      (w_lockTc)
   );

   reset_seq_counter #(
      .WIDTH  (CNT_W),
      .TC_VAL (GAP_TC)
   ) u_gapCnt (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_gapClr),
      .i_load    (1'b0),
      .i_loadVal ('0),
      .i_inc     (w_gapInc),
      .o_count   (w_gapCnt),
      .o_tc      (w_gapTc)
   );

   reset_seq_counter #(
      .WIDTH  (CNT_W),
      .TC_VAL (HOLD_TC)
   ) u_holdCnt (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_holdClr),
      .i_load    (1'b0),
      .i_loadVal ('0),
      .i_inc     (w_holdInc),
      .o_count   (w_holdCnt),
      .o_tc      (w_holdTc)
   );

   // Sequencing FSM with registered outputs; software request outranks
   // lock loss, which outranks normal progression.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= WAIT_LOCK;
         r_rstOut   <= '1;
         r_seqDone  <= 1'b0;
         r_stageIdx <= '0;
      end else if (w_swAccept) begin
         r_state    <= SW_HOLD_ST;
         r_rstOut   <= '1;
         r_seqDone  <= 1'b0;
         r_stageIdx <= '0;
      end else if (w_lockLoss) begin
         r_state    <= WAIT_LOCK;
         r_rstOut   <= '1;
         r_seqDone  <= 1'b0;
         r_stageIdx <= '0;
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               r_rstOut   <= '1;
               r_seqDone  <= 1'b0;
               r_stageIdx <= '0;
               if (pll_lock) begin
                  r_state <= LOCK_FILT;
               end
            end
            LOCK_FILT: begin
               if (!pll_lock) begin
                  r_state <= WAIT_LOCK;
               end else if (w_lockTc) begin
                  r_state <= RELEASE;
               end
            end
            RELEASE: begin
               if (w_gapTc) begin
                  r_rstOut   <= r_rstOut & ~(NUM_STAGES'(1) << r_stageIdx);
                  r_stageIdx <= r_stageIdx + IDX_W'(1);
                  if (r_stageIdx == IDX_W'(NUM_STAGES - 1)) begin
                     r_state   <= RUN;
                     r_seqDone <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_rstOut   <= '0;
               r_seqDone  <= 1'b1;
               r_stageIdx <= IDX_W'(NUM_STAGES);
            end
            SW_HOLD_ST: begin
               if (w_holdTc) begin
                  r_state <= LOCK_FILT;
               end
            end
            default: begin
               r_state    <= WAIT_LOCK;
               r_rstOut   <= '1;
               r_seqDone  <= 1'b0;
               r_stageIdx <= '0;
            end
         endcase
      end
   end

   // Counter ceilings: each timer is cleared at its terminal count, so none should run past it.
   assert property (@(posedge clk) disable iff (reset) w_lockCnt <= LOCK_MAX);
   assert property (@(posedge clk) disable iff (reset) w_gapCnt <= GAP_TC);
   assert property (@(posedge clk) disable iff (reset) w_holdCnt <= HOLD_TC);

   assign rst_out   = r_rstOut;
   assign seq_done  = r_seqDone;
   assign stage_idx = r_stageIdx;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters. Edge counts in
// the comments are numbered from the first clock edge after the event that
// starts each scenario (reset deassert, lock, or software pulse).
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       pll_lock;
   logic       sw_rst_req;
   logic [3:0] rst_out;
   logic       seq_done;
   logic [2:0] stage_idx;

   int checkCount = 0;
   int errorCount = 0;

   reset_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .sw_rst_req (sw_rst_req),
      .rst_out    (rst_out),
      .seq_done   (seq_done),
      .stage_idx  (stage_idx)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rstIn, input logic lockIn, input logic swIn);
      reset      = rstIn;
      pll_lock   = lockIn;
      sw_rst_req = swIn;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkAll(input string tag, input logic [3:0] expRst, input logic expDone, input logic [2:0] expIdx);
      checkOutput({tag, ".rst_out"}, 32'(rst_out), 32'(expRst));
      checkOutput({tag, ".seq_done"}, 32'(seq_done), 32'(expDone));
      checkOutput({tag, ".stage_idx"}, 32'(stage_idx), 32'(expIdx));
   endtask

   initial begin
      // Power-up: reset 5 cycles with lock already high.
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(5);
      checkAll("por", 4'b1111, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(40);
      checkAll("pu.filt40", 4'b1111, 1'b0, 3'd0);
      tick(39);
      checkAll("pu.e79", 4'b1111, 1'b0, 3'd0);
      tick(1);
      checkAll("pu.e80", 4'b1110, 1'b0, 3'd1);
      tick(15);
      checkAll("pu.e95", 4'b1110, 1'b0, 3'd1);
      tick(1);
      checkAll("pu.e96", 4'b1100, 1'b0, 3'd2);
      tick(16);
      checkAll("pu.e112", 4'b1000, 1'b0, 3'd3);
      tick(15);
      checkAll("pu.e127", 4'b1000, 1'b0, 3'd3);
      tick(1);
      checkAll("pu.e128", 4'b0000, 1'b1, 3'd4);
      tick(10);
      checkAll("pu.run", 4'b0000, 1'b1, 3'd4);

      // Lock glitch at filter count 40: relock at edge 42, release at 42+63+16.
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(2);
      checkAll("gl.rst", 4'b1111, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(40);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(1);
      checkAll("gl.drop", 4'b1111, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(39);
      checkAll("gl.e80", 4'b1111, 1'b0, 3'd0);
      tick(40);
      checkAll("gl.e120", 4'b1111, 1'b0, 3'd0);
      tick(1);
      checkAll("gl.e121", 4'b1110, 1'b0, 3'd1);
      tick(48);
      checkAll("gl.e169", 4'b0000, 1'b1, 3'd4);

      // Software reset from RUN: hold 8, filter 64, gap 16 -> bit0 at pulse+88.
      applyStimulus(1'b0, 1'b1, 1'b1);
      tick(1);
      checkAll("sw.s0", 4'b1111, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(87);
      checkAll("sw.s87", 4'b1111, 1'b0, 3'd0);
      tick(1);
      checkAll("sw.s88", 4'b1110, 1'b0, 3'd1);
      tick(32);
      checkAll("sw.s120", 4'b1000, 1'b0, 3'd3);
      tick(16);
      checkAll("sw.s136", 4'b0000, 1'b1, 3'd4);

      // Repeated request at hold count 5: hold restarts, bit0 moves from s88 to s94.
      applyStimulus(1'b0, 1'b1, 1'b1);
      tick(1);
      checkAll("rp.s0", 4'b1111, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(5);
      applyStimulus(1'b0, 1'b1, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(82);
      checkAll("rp.s88", 4'b1111, 1'b0, 3'd0);
      tick(5);
      checkAll("rp.s93", 4'b1111, 1'b0, 3'd0);
      tick(1);
      checkAll("rp.s94", 4'b1110, 1'b0, 3'd1);
      tick(16);
      checkAll("rp.s110", 4'b1100, 1'b0, 3'd2);

      // Reset mid-RELEASE, then a software pulse in WAIT_LOCK that must be ignored.
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(1);
      checkAll("mr.rst", 4'b1111, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(2);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick(1);
      checkAll("mr.swign", 4'b1111, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(79);
      checkAll("mr.e79", 4'b1111, 1'b0, 3'd0);
      tick(1);
      checkAll("mr.e80", 4'b1110, 1'b0, 3'd1);
      tick(48);
      checkAll("mr.e128", 4'b0000, 1'b1, 3'd4);

      // Lock loss while in RUN.
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(1);
`ifdef RESET_SEQ_LOCK_LOSS_EN
      checkAll("ll.drop", 4'b1111, 1'b0, 3'd0);
      tick(5);
      checkAll("ll.hold", 4'b1111, 1'b0, 3'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(1);
      checkAll("ll.relock", 4'b1111, 1'b0, 3'd0);
`else
      checkAll("ll.drop", 4'b0000, 1'b1, 3'd4);
      tick(5);
      checkAll("ll.hold", 4'b0000, 1'b1, 3'd4);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(1);
      checkAll("ll.relock", 4'b0000, 1'b1, 3'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
